// File: rtl/x_stream_gen.sv
// x_stream_gen: shifts a loadable pattern out LSB-first on x, optionally repeated.
// Ports: clk, res (sync high), load/pattern/len/rpt, start, stop -> x, frame, busy, done.
module x_stream_gen #(
  parameter int       WIDTH  = 8,
  parameter int       LEN_W  = 4,
  parameter int       RPT_W  = 4,
  parameter logic     IDLE_X = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [RPT_W-1:0] rpt,
  input  logic             start,
  input  logic             stop,
  output logic             x,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Values a start in this cycle would use (a same-cycle load wins).
  logic [WIDTH-1:0] pat_eff;
  logic [LEN_W-1:0] len_eff;
  logic [RPT_W-1:0] rpt_eff;

  logic [LEN_W-1:0] idx_inc;
  logic [WIDTH-1:0] pat_sh;

  always_comb begin
    len_eff = len;
    if (len == '0 || len > LEN_MAX) begin
      len_eff = LEN_MAX;
    end
    pat_eff = load ? pattern : pat_q;
    if (!load) begin
      len_eff = len_q;
    end
    rpt_eff = load ? rpt : rpt_q;
  end

  assign idx_inc = idx_q + LEN_W'(1);
  assign pat_sh  = pat_q >> idx_inc;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_d     = IDLE_X;
        frame_d = 1'b0;
        busy_d  = 1'b0;
        if (load) begin
          pat_d = pat_eff;
          len_d = len_eff;
          rpt_d = rpt_eff;
        end
        if (start && !stop) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = rpt_eff;
          x_d     = pat_eff[0];
          frame_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          x_d     = IDLE_X;
          frame_d = 1'b0;
          busy_d  = 1'b0;
        end else if (idx_inc < len_q) begin
          idx_d = idx_inc;
          x_d   = pat_sh[0];
        end else if (cnt_q != '0) begin
          // Next repetition starts immediately, no gap.
          cnt_d = cnt_q - RPT_W'(1);
          idx_d = '0;
          x_d   = pat_q[0];
        end else begin
          state_d = S_IDLE;
          x_d     = IDLE_X;
          frame_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        x_d     = IDLE_X;
        frame_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= LEN_MAX;
      rpt_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_X;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rpt_q   <= rpt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign frame = frame_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_x_stream_gen.sv
// Testbench for x_stream_gen: directed scenarios plus random traffic,
// per-cycle expectations queued by a reference model, popped by a monitor.
module tb_x_stream_gen;

  logic       clk = 1'b0;
  logic       res;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rpt;
  logic       start;
  logic       stop;
  logic       x;
  logic       frame;
  logic       busy;
  logic       done;

  x_stream_gen dut (
    .clk(clk), .res(res), .load(load),
    .pattern(pattern), .len(len), .rpt(rpt),
    .start(start), .stop(stop),
    .x(x), .frame(frame), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic fr;
    logic dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   dones  = 0;
  int   dones_exp = 0;

  logic [7:0] m_pat;
  int         m_len;
  int         m_rpt;

  // Model: a run is fully predicted at start; the queue being non-empty
  // means the block is running at the coming edge.
  task automatic drive(input logic l, input logic [7:0] p,
                       input logic [3:0] ln, input logic [3:0] r,
                       input logic s, input logic sp, input logic rs);
    @(negedge clk);
    load = l; pattern = p; len = ln; rpt = r;
    start = s; stop = sp; res = rs;
    if (rs) begin
      exp_q.delete();
      m_pat = 8'h00; m_len = 8; m_rpt = 0;
    end else if (exp_q.size() != 0) begin
      if (sp) exp_q.delete();
    end else begin
      if (l) begin
        m_pat = p;
        m_len = (ln == 4'd0 || ln > 4'd8) ? 8 : int'(ln);
        m_rpt = int'(r);
      end
      if (s && !sp) begin
        for (int k = 0; k <= m_rpt; k++)
          for (int b = 0; b < m_len; b++)
            exp_q.push_back('{x: m_pat[b], fr: 1'b1, dn: 1'b0});
        exp_q.push_back('{x: 1'b0, fr: 1'b0, dn: 1'b1});
        dones_exp++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [7:0] p, input logic [3:0] ln,
                    input logic [3:0] r);
    drive(1'b1, p, ln, r, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '{x: 1'b0, fr: 1'b0, dn: 1'b0};
      if (done === 1'b1) dones++;
      checks++;
      if (x === e.x && frame === e.fr && busy === e.fr && done === e.dn)
        passes++;
      else
        $display("FAIL cycle t=%0t x/frame/busy/done got %b%b%b%b want %b%b%b%b",
                 $time, x, frame, busy, done, e.x, e.fr, e.fr, e.dn);
    end
  end

  initial begin : stim
    m_pat = 8'h00; m_len = 8; m_rpt = 0;
    res = 1'b1; load = 1'b1; start = 1'b1; stop = 1'b0;
    pattern = 8'hFF; len = 4'd3; rpt = 4'd2;

    drive(1'b1, 8'hFF, 4'd3, 4'd2, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'hFF, 4'd3, 4'd2, 1'b1, 1'b0, 1'b1);
    go();
    idle(10);

    ld(8'hB2, 4'd8, 4'd0);
    go();
    idle(10);

    ld(8'h06, 4'd3, 4'd2);
    go();
    idle(12);

    ld(8'hB2, 4'd8, 4'd0);
    go();
    idle(3);
    drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    go();
    idle(10);

    go();
    drive(1'b1, 8'hFF, 4'd8, 4'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0);
    idle(10);
    ld(8'h5A, 4'd0, 4'd0);
    go();
    idle(10);
    ld(8'h3C, 4'd12, 4'd1);
    go();
    idle(18);
    drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    idle(3);

    ld(8'hB2, 4'd8, 4'd0);
    go();
    idle(8);
    go();
    idle(4);
    drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(5);

    ld(8'hA5, 4'd1, 4'd15);
    go();
    idle(20);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] p;
      logic [3:0] ln, r;
      logic       l, s, sp, rs;
      p  = 8'($urandom);
      ln = 4'($urandom);
      r  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      l  = ($urandom_range(0, 4) == 0);
      s  = ($urandom_range(0, 4) == 0);
      sp = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 79) == 0);
      drive(l, p, ln, r, s, sp, rs);
    end
    drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(3);

    checks++;
    if (dones <= dones_exp) passes++;
    else $display("FAIL done_count got %0d want at most %0d", dones, dones_exp);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
